instr_fetch_unit: RTL

Instruction fetch stage of the Laji MIPS core, directly upstream of the combinational control decoder. It holds the program counter, issues word reads to a synchronous-read instruction memory, and buffers returned instructions in a 2-entry queue so the decoder can stall without losing in-flight fetches. It also accepts PC redirects from jump/branch resolution and a sticky halt from syscall handling. The decoder consumes `inst[31:26]`, `inst[20:16]` and `inst[5:0]` from this block's output.

---
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decoder handshake, redirect/halt control and
// performance counters. master = fetch unit, slave = memory/decoder/control side.
interface instr_fetch_unit_if #(
   parameter int unsigned IMEM_ADDR_BITS = 10
);
   logic [IMEM_ADDR_BITS-1:0] imem_addr;
   logic [31:0]               imem_data;
   logic                      inst_valid;
   logic [31:0]               inst;
   logic [31:0]               inst_pc;
   logic [31:0]               inst_pc4;
   logic                      inst_ready;
   logic                      redirect_en;
   logic [31:0]               redirect_pc;
   logic                      halt;
   logic                      resume;
   logic                      halted;
   logic [31:0]               fetch_cnt;
   logic [31:0]               flush_cnt;

   modport master (
      output imem_addr, inst_valid, inst, inst_pc, inst_pc4, halted, fetch_cnt, flush_cnt,
      input  imem_data, inst_ready, redirect_en, redirect_pc, halt, resume
   );

   modport slave (
      input  imem_addr, inst_valid, inst, inst_pc, inst_pc4, halted, fetch_cnt, flush_cnt,
      output imem_data, inst_ready, redirect_en, redirect_pc, halt, resume
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Laji MIPS fetch stage: PC, synchronous imem requests, 2-entry instruction buffer, redirect/halt.
// Define FETCH_PERF_CNT_EN to build the fetch/flush performance counters (tied to 0 otherwise).
module instr_fetch_unit #(
   parameter logic [31:0] PC_RESET       = 32'h0000_0000,
   parameter int unsigned IMEM_ADDR_BITS = 10
) (
   input logic                clk,
   input logic                rst_n,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [0:0] {StFetch, StHalted} state_e;

   state_e      state_q, state_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] inflight_pc_q;
   logic        inflight_q, inflight_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [31:0] fifo_inst_q [2];
   logic [31:0] fifo_pc_q   [2];

   logic head_valid;
   logic pop;
   logic push;
   logic issue;
   logic space_ok;
   logic unused_pc_lsbs;

   assign head_valid     = (count_q != 2'd0);
   assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

   always_comb begin
      pop      = head_valid && bus.inst_ready;
      // Returning data is dropped when a redirect flushes the stage in the same cycle.
      push     = inflight_q && !bus.redirect_en;
      // Occupancy after this cycle's pop must leave room for the word being requested.
      space_ok = ({1'b0, count_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});
      issue    = (state_q == StFetch) && !bus.halt && !bus.redirect_en && space_ok;

      state_d = state_q;
      unique case (state_q)
         StFetch:  if (bus.halt) state_d = StHalted;
         StHalted: if (bus.resume && !bus.halt) state_d = StFetch;
         default:  state_d = StFetch;
      endcase

      req_pc_d = req_pc_q;
      if (bus.redirect_en) begin
         req_pc_d = {bus.redirect_pc[31:2], 2'b00};
      end else if (issue) begin
         req_pc_d = req_pc_q + 32'd4;
      end

      inflight_d = issue;
      rd_ptr_d   = rd_ptr_q ^ pop;
      if (bus.redirect_en) begin
         count_d  = 2'd0;
         wr_ptr_d = rd_ptr_d;
      end else begin
         count_d  = count_q - {1'b0, pop} + {1'b0, push};
         wr_ptr_d = wr_ptr_q ^ push;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StFetch;
         req_pc_q      <= PC_RESET;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         count_q       <= 2'd0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (issue) inflight_pc_q <= req_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst_q[wr_ptr_q] <= bus.imem_data;
         fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push && !pop) assert (count_q != 2'd2);
   end

   always_comb begin
      bus.imem_addr  = req_pc_q[IMEM_ADDR_BITS+1:2];
      bus.inst_valid = head_valid;
      bus.inst       = 32'h0;
      bus.inst_pc    = 32'h0;
      bus.inst_pc4   = 32'h0;
      bus.halted     = (state_q == StHalted);
      if (head_valid) begin
         bus.inst     = fifo_inst_q[rd_ptr_q];
         bus.inst_pc  = fifo_pc_q[rd_ptr_q];
         bus.inst_pc4 = fifo_pc_q[rd_ptr_q] + 32'd4;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         if (pop)             fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (bus.redirect_en) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign bus.fetch_cnt = fetch_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.fetch_cnt = 32'h0;
   assign bus.flush_cnt = 32'h0;
`endif

endmodule
